// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder.
// Captures a request vector on LOAD and emits the index of every set bit as
// {A,B,C} (A = MSB), one code per accepted handshake, in fixed priority order.
// The {A,B,C} ordering matches the 3-to-8 decoder's inputs, so decoding an
// emitted code gives back the original one-hot request line.
//
// Handshake: a code is transferred on a rising CLK edge where VALID=1 and
// READY=1. While READY=0, {A,B,C}, VALID and the pending set stay frozen.
// LOAD is only looked at when BUSY=0. A LOAD held during the final
// handshake is therefore ignored and first takes effect one cycle later.
module encoder_8x3_seq #(
  parameter bit PRIORITY_HIGH = 1'b1  // 1: D[7] first (descending), 0: D[0] first
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic       LOAD,
  input  logic       READY,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       VALID,
  output logic       BUSY,
  output logic       MULTI,
  output logic       DBG_STATE  // current FSM state: 0 = IDLE, 1 = EMIT
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pending;
  logic [7:0] w_pending_nxt;
  logic [2:0] r_code;
  logic [2:0] w_code_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_multi;
  logic       w_multi_nxt;
  logic [7:0] w_rem;

  // Index of the highest-priority set bit. The scan direction is fixed by
  // PRIORITY_HIGH and never rotates. Returns 0 for an all-zero vector; the
  // FSM never calls it with zero.
  function automatic logic [2:0] f_pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = i[2:0];  // the last hit is the highest index
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = i[2:0];  // the last hit is the lowest index
      end
    end
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic f_multi(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_code_nxt    = r_code;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_multi_nxt   = r_multi;
    // Pending set with the code currently on {A,B,C} removed
    w_rem         = r_pending & ~(8'd1 << r_code);

    case (r_state)
      IDLE: begin
        if (LOAD) begin
          if (D != 8'd0) begin
            w_pending_nxt = D;
            w_code_nxt    = f_pick(D);
            w_valid_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
            w_multi_nxt   = f_multi(D);
            w_state_nxt   = EMIT;
          end else begin
            // Empty request: nothing to emit, but it still counts as the
            // last accepted vector for MULTI.
            w_multi_nxt = 1'b0;
          end
        end
      end
      EMIT: begin
        if (r_valid && READY) begin
          w_pending_nxt = w_rem;
          if (w_rem != 8'd0) begin
            // Next code follows immediately, with no bubble.
            w_code_nxt = f_pick(w_rem);
          end else begin
            // Last code taken. {A,B,C} keeps its final value.
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending bits at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_pending <= 8'd0;
      r_code    <= 3'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_multi   <= w_multi_nxt;
    end
  end

  assign {A, B, C} = r_code;
  assign VALID     = r_valid;
  assign BUSY      = r_busy;
  assign MULTI     = r_multi;
  assign DBG_STATE = r_state;

endmodule

// File: doc/encoder_8x3_seq.md
Name: encoder_8x3_seq

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder, used to turn ALU status/request lines back into a 3-bit code.
- Latches an 8-bit request vector and emits the index of every set bit as {A,B,C}, one per accepted handshake, in priority order.
- Sits between flag/request sources and the opcode/select path feeding the decoder.
- {A,B,C} uses the decoder's input ordering, A = MSB, so decoding an emitted code reproduces the original one-hot line.

Parameters:
- PRIORITY_HIGH, 1, 1 = D[7] highest priority (emit descending index); 0 = D[0] highest (emit ascending index).

Ports:
- CLK  input  1  Single clock; all state changes on the rising edge.
- RST  input  1  Asynchronous, active-high reset.
- D  input  8  Request vector; sampled only on an accepted LOAD.
- LOAD  input  1  Capture D; honoured only while BUSY=0.
- READY  input  1  Consumer accepts the current code when VALID=1.
- A  output  1  Encoded index bit 2 (MSB).
- B  output  1  Encoded index bit 1.
- C  output  1  Encoded index bit 0 (LSB).
- VALID  output  1  {A,B,C} holds a pending index.
- BUSY  output  1  Block is emitting; LOAD is ignored.
- MULTI  output  1  Last accepted vector had more than one bit set.

Behaviour:
- All outputs are registered. RST=1 asynchronously clears the pending register and sets A=B=C=0, VALID=0, BUSY=0, MULTI=0, state=IDLE.
- RST asserted mid-emission discards the remaining pending bits immediately. After RST deasserts, the block stays in IDLE until the next LOAD.
- States: IDLE, EMIT.
- IDLE, LOAD=1, D!=0:
  - pending<=D.
  - {A,B,C}<=index of the highest-priority set bit of D.
  - VALID<=1, BUSY<=1, MULTI<=(popcount(D)>1).
  - Next state EMIT. Latency LOAD edge -> VALID high is 1 cycle.
- IDLE, LOAD=1, D=0: MULTI<=0; state, VALID and BUSY unchanged (VALID stays 0, no emission).
- IDLE, LOAD=0: hold.
- EMIT, handshake (VALID & READY at an edge):
  - rem = pending & ~onehot({A,B,C}); pending<=rem.
  - If rem!=0: {A,B,C}<=highest-priority index of rem, VALID stays 1, giving back-to-back codes with no bubble.
  - If rem=0: VALID<=0, BUSY<=0, {A,B,C} holds its last value, next state IDLE.
- EMIT, READY=0: A, B, C, VALID and pending are all held stable (no glitch, no skip).
- LOAD while BUSY=1 is ignored, including in the cycle of the final handshake. A LOAD is first honoured in the cycle after BUSY falls.
- MULTI holds from one accepted LOAD to the next (or until reset).
- Each set bit of D is emitted exactly once. The number of codes emitted equals popcount(D).
- Priority select is a fixed scan by PRIORITY_HIGH; there is no wrap-around or rotation.

Test Plan:
1. RST pulse mid-emission, with D=8'hFF loaded and 2 codes accepted -> VALID, BUSY and MULTI fall in the same cycle as RST, with no clock edge needed; after release, no further codes appear until a new LOAD.
2. LOAD D=8'b0010_0000, READY=1 -> next cycle {A,B,C}=101, VALID=1, MULTI=0; following cycle VALID=0, BUSY=0.
3. PRIORITY_HIGH=1, LOAD D=8'b1000_0101, READY=1 -> {A,B,C}=111, 010, 000 on 3 consecutive cycles, VALID high for exactly 3 cycles, MULTI=1. With PRIORITY_HIGH=0 -> 000, 010, 111.
4. Back-pressure: same load, READY=0 for 4 cycles -> {A,B,C}=111 and VALID=1 held throughout; a LOAD D=8'h01 during EMIT is ignored; then READY=1 -> remaining codes 010, 000 follow.
5. LOAD D=8'h00 in IDLE -> VALID stays 0, BUSY stays 0, MULTI=0.
6. Sweep each one-hot D=1<<i for i=0..7 -> single code {A,B,C}=i; feeding the code through the 3-to-8 decoder reproduces D; MULTI=0.
